// File: rtl/ads1299_pkg.sv
// Shared types and constants for the ADS1299 read-data frame parser.
package ads1299_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STATUS = 2'd1,
    CHAN   = 2'd2
  } state_e;

  localparam logic [3:0] STATUS_SYNC    = 4'hC;
  localparam int         BYTES_PER_WORD = 3;
  localparam int         ADS_WORD_W     = 24;

  // A status word is trusted only when its top nibble carries the sync pattern.
  function automatic logic status_ok(input logic [ADS_WORD_W-1:0] word);
    return (word[ADS_WORD_W-1 -: 4] == STATUS_SYNC);
  endfunction

endpackage

// File: rtl/ads1299_word_assembler.sv
// Packs accepted bytes MSB first into 24-bit words; a clear restarts the word and
// may take the same-cycle byte as the first byte of the new word.
module ads1299_word_assembler
  import ads1299_pkg::*;
(
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_clear,
  input  logic                  i_enable,
  input  logic [7:0]            i_byte,
  input  logic                  i_byte_valid,
  output logic                  o_word_done,
  output logic [ADS_WORD_W-1:0] o_word
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  r_cnt;
  logic [15:0] r_shift;
  logic        w_take;

  assign w_take      = i_byte_valid & (i_clear | i_enable);
  assign o_word_done = w_take & ~i_clear & (r_cnt == LAST_IDX);
  assign o_word      = {r_shift, i_byte};

  // Byte counter and shift register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt   <= 2'd0;
      r_shift <= 16'd0;
    end else if (i_clear) begin
      r_cnt   <= w_take ? 2'd1 : 2'd0;
      r_shift <= {8'd0, (w_take ? i_byte : 8'd0)};
    end else if (w_take) begin
      r_cnt   <= (r_cnt == LAST_IDX) ? 2'd0 : (r_cnt + 2'd1);
      r_shift <= {r_shift[7:0], i_byte};
    end else begin
      r_cnt   <= r_cnt;
      r_shift <= r_shift;
    end
  end

endmodule

// File: rtl/ads1299_frame_parser.sv
// ADS1299 read-data parser: status check, per-channel sign-extended samples and a
// once-per-frame stream of the selected channel. All outputs are registered.
module ads1299_frame_parser
  import ads1299_pkg::*;
#(
  parameter int N_CH   = 8,
  parameter int Q_OUT  = 32,
  parameter int CH_SEL = 0
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_frame_start,
  input  logic [7:0]            i_byte_in,
  input  logic                  i_byte_valid,
  output logic [Q_OUT-1:0]      o_ch_data_out,
  output logic [2:0]            o_ch_id,
  output logic                  o_ch_valid,
  output logic [Q_OUT-1:0]      o_sel_data_out,
  output logic                  o_sel_valid,
  output logic [ADS_WORD_W-1:0] o_status_out,
  output logic                  o_status_valid,
  output logic                  o_frame_error
);

  localparam logic [2:0] LAST_CH = 3'(N_CH - 1);
  localparam logic [2:0] SEL_CH  = 3'(CH_SEL);

  function automatic logic [Q_OUT-1:0] sign_extend(input logic [ADS_WORD_W-1:0] w);
    return Q_OUT'($signed(w));
  endfunction

  state_e                  r_state, w_state_nxt;
  logic [2:0]              r_ch_cnt, w_ch_cnt_nxt;
  logic [Q_OUT-1:0]        r_ch_data, w_ch_data_nxt;
  logic [2:0]              r_ch_id, w_ch_id_nxt;
  logic                    r_ch_valid, w_ch_valid_nxt;
  logic [Q_OUT-1:0]        r_sel_data, w_sel_data_nxt;
  logic                    r_sel_valid, w_sel_valid_nxt;
  logic [ADS_WORD_W-1:0]   r_status, w_status_nxt;
  logic                    r_status_valid, w_status_valid_nxt;
  logic                    r_frame_error, w_frame_error_nxt;

  logic                    w_word_done;
  logic [ADS_WORD_W-1:0]   w_word;

  ads1299_word_assembler u_asm (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_clear      (i_frame_start),
    .i_enable     (r_state != IDLE),
    .i_byte       (i_byte_in),
    .i_byte_valid (i_byte_valid),
    .o_word_done  (w_word_done),
    .o_word       (w_word)
  );

  // State and output registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state        <= IDLE;
      r_ch_cnt       <= 3'd0;
      r_ch_data      <= '0;
      r_ch_id        <= 3'd0;
      r_ch_valid     <= 1'b0;
      r_sel_data     <= '0;
      r_sel_valid    <= 1'b0;
      r_status       <= '0;
      r_status_valid <= 1'b0;
      r_frame_error  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_ch_cnt       <= w_ch_cnt_nxt;
      r_ch_data      <= w_ch_data_nxt;
      r_ch_id        <= w_ch_id_nxt;
      r_ch_valid     <= w_ch_valid_nxt;
      r_sel_data     <= w_sel_data_nxt;
      r_sel_valid    <= w_sel_valid_nxt;
      r_status       <= w_status_nxt;
      r_status_valid <= w_status_valid_nxt;
      r_frame_error  <= w_frame_error_nxt;
    end
  end

  // Next-state and next-output logic; frame_start overrides whatever is in flight.
  always_comb begin
    w_state_nxt        = r_state;
    w_ch_cnt_nxt       = r_ch_cnt;
    w_ch_data_nxt      = r_ch_data;
    w_ch_id_nxt        = r_ch_id;
    w_ch_valid_nxt     = 1'b0;
    w_sel_data_nxt     = r_sel_data;
    w_sel_valid_nxt    = 1'b0;
    w_status_nxt       = r_status;
    w_status_valid_nxt = 1'b0;
    w_frame_error_nxt  = 1'b0;

    if (i_frame_start) begin
      w_frame_error_nxt = (r_state != IDLE);
      w_state_nxt       = STATUS;
      w_ch_cnt_nxt      = 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = IDLE;
        end
        STATUS: begin
          if (w_word_done && status_ok(w_word)) begin
            w_status_nxt       = w_word;
            w_status_valid_nxt = 1'b1;
            w_state_nxt        = CHAN;
            w_ch_cnt_nxt       = 3'd0;
          end else if (w_word_done) begin
            w_frame_error_nxt = 1'b1;
            w_state_nxt       = IDLE;
          end else begin
            w_state_nxt = STATUS;
          end
        end
        CHAN: begin
          if (w_word_done) begin
            w_ch_data_nxt  = sign_extend(w_word);
            w_ch_id_nxt    = r_ch_cnt;
            w_ch_valid_nxt = 1'b1;
            if (r_ch_cnt == SEL_CH) begin
              w_sel_data_nxt  = sign_extend(w_word);
              w_sel_valid_nxt = 1'b1;
            end else begin
              w_sel_valid_nxt = 1'b0;
            end
            if (r_ch_cnt == LAST_CH) begin
              w_state_nxt  = IDLE;
              w_ch_cnt_nxt = 3'd0;
            end else begin
              w_ch_cnt_nxt = r_ch_cnt + 3'd1;
            end
          end else begin
            w_state_nxt = CHAN;
          end
        end
        default: begin
          w_state_nxt  = IDLE;
          w_ch_cnt_nxt = 3'd0;
        end
      endcase
    end
  end

  assign o_ch_data_out  = r_ch_data;
  assign o_ch_id        = r_ch_id;
  assign o_ch_valid     = r_ch_valid;
  assign o_sel_data_out = r_sel_data;
  assign o_sel_valid    = r_sel_valid;
  assign o_status_out   = r_status;
  assign o_status_valid = r_status_valid;
  assign o_frame_error  = r_frame_error;

endmodule

// File: tb/tb_ads1299_frame_parser.sv
// Directed and randomized bench for ads1299_frame_parser against a byte-index
// reference model of the frame format.
module tb_ads1299_frame_parser;

  localparam int N_CH   = 8;
  localparam int Q_OUT  = 32;
  localparam int CH_SEL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1;
  logic             fs    = 1'b0;
  logic             bv    = 1'b0;
  logic [7:0]       bin   = 8'd0;
  logic [Q_OUT-1:0] ch_data, sel_data;
  logic [2:0]       ch_id;
  logic             ch_valid, sel_valid, st_valid, ferr;
  logic [23:0]      status;

  ads1299_frame_parser #(.N_CH(N_CH), .Q_OUT(Q_OUT), .CH_SEL(CH_SEL)) dut (
    .i_clock        (clk),
    .i_reset        (reset),
    .i_frame_start  (fs),
    .i_byte_in      (bin),
    .i_byte_valid   (bv),
    .o_ch_data_out  (ch_data),
    .o_ch_id        (ch_id),
    .o_ch_valid     (ch_valid),
    .o_sel_data_out (sel_data),
    .o_sel_valid    (sel_valid),
    .o_status_out   (status),
    .o_status_valid (st_valid),
    .o_frame_error  (ferr)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_ch_seen  = 0;
  int n_sel_seen = 0;
  int n_err_seen = 0;

  // Reference model: bytes of the current frame plus expected output values.
  bit          m_active = 1'b0;
  logic [7:0]  m_q[$];
  logic [31:0] e_ch_data = '0, e_sel_data = '0;
  logic [2:0]  e_ch_id = '0;
  logic [23:0] e_status = '0;
  bit          e_ch_valid, e_sel_valid, e_st_valid, e_ferr;

  logic [7:0]  tx_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] to_signed32(input logic [23:0] w);
    int v;
    v = int'(w);
    if (v >= 8388608) v = v - 16777216;
    return 32'(v);
  endfunction

  task automatic model(input bit rst, input bit f, input bit v, input logic [7:0] b);
    int k, widx, ch;
    logic [23:0] word;
    e_ch_valid = 0; e_sel_valid = 0; e_st_valid = 0; e_ferr = 0;
    if (rst) begin
      m_active = 0; m_q.delete();
      e_ch_data = '0; e_sel_data = '0; e_ch_id = '0; e_status = '0;
    end else begin
      if (f) begin
        e_ferr = m_active;
        m_active = 1;
        m_q.delete();
      end
      if (v && m_active) begin
        m_q.push_back(b);
        k = m_q.size() - 1;
        if (k % 3 == 2) begin
          word = {m_q[k-2], m_q[k-1], m_q[k]};
          widx = k / 3;
          if (widx == 0) begin
            if (word[23:20] == 4'hC) begin
              e_status = word; e_st_valid = 1;
            end else begin
              e_ferr = 1; m_active = 0;
            end
          end else begin
            ch = widx - 1;
            e_ch_data = to_signed32(word); e_ch_id = 3'(ch); e_ch_valid = 1;
            if (ch == CH_SEL) begin
              e_sel_data = e_ch_data; e_sel_valid = 1;
            end
            if (ch == N_CH - 1) m_active = 0;
          end
        end
      end
    end
  endtask

  // One clock cycle: drive at negedge, update model, check #1 after the posedge.
  task automatic step(input bit rst, input bit f, input bit v, input logic [7:0] b);
    @(negedge clk);
    reset = rst; fs = f; bv = v; bin = b;
    model(rst, f, v, b);
    @(posedge clk);
    #1;
    chk("ch_valid",     64'(ch_valid),  64'(e_ch_valid));
    chk("sel_valid",    64'(sel_valid), 64'(e_sel_valid));
    chk("status_valid", 64'(st_valid),  64'(e_st_valid));
    chk("frame_error",  64'(ferr),      64'(e_ferr));
    chk("ch_data",      64'(ch_data),   64'(e_ch_data));
    chk("ch_id",        64'(ch_id),     64'(e_ch_id));
    chk("sel_data",     64'(sel_data),  64'(e_sel_data));
    chk("status_out",   64'(status),    64'(e_status));
    if (ch_valid === 1'b1) n_ch_seen++;
    if (sel_valid === 1'b1) n_sel_seen++;
    if (ferr === 1'b1) n_err_seen++;
  endtask

  // mode 0: no frame_start, 1: frame_start alone first, 2: frame_start with first byte.
  task automatic send_q(input int maxgap, input int mode);
    if (mode == 1) step(0, 1, 0, 8'($urandom));
    for (int i = 0; i < tx_q.size(); i++) begin
      if (i > 0 || mode != 2)
        for (int g = $urandom_range(maxgap, 0); g > 0; g--) step(0, 0, 0, 8'($urandom));
      step(0, (mode == 2 && i == 0), 1, tx_q[i]);
    end
    tx_q.delete();
  endtask

  task automatic push_word(input logic [23:0] w);
    tx_q.push_back(w[23:16]); tx_q.push_back(w[15:8]); tx_q.push_back(w[7:0]);
  endtask

  task automatic push_frame(input logic [23:0] st, input logic [23:0] base, input bit rnd);
    push_word(st);
    for (int k = 0; k < N_CH; k++) push_word(rnd ? 24'($urandom) : base + 24'(k));
  endtask

  initial begin
    step(1, 0, 0, 8'd0);
    step(1, 0, 1, 8'hAA);
    chk("reset_ch_data", 64'(ch_data), 64'd0);
    chk("reset_status",  64'(status),  64'd0);

    // Good frame, back to back.
    n_ch_seen = 0; n_sel_seen = 0;
    push_frame(24'hC00000, 24'h000100, 0);
    send_q(0, 1);
    step(0, 0, 0, 8'd0);
    chk("good_ch_count",  64'(n_ch_seen),  64'd8);
    chk("good_sel_count", 64'(n_sel_seen), 64'd1);
    chk("good_sel_value", 64'(sel_data),   64'd258);
    chk("good_last_id",   64'(ch_id),      64'd7);

    // Negative samples on channel 0.
    push_word(24'hC12345); push_word(24'hFFFFFE);
    send_q(0, 2);
    chk("neg_minus2", 64'(ch_data), 64'h0000_0000_FFFF_FFFE);
    for (int k = 1; k < N_CH; k++) push_word(24'($urandom));
    send_q(0, 0);
    push_word(24'hC00001); push_word(24'h800000);
    send_q(1, 1);
    chk("neg_min", 64'(ch_data), 64'h0000_0000_FF80_0000);
    for (int k = 1; k < N_CH; k++) push_word(24'($urandom));
    send_q(0, 0);

    // Bad header, trailing bytes ignored.
    n_ch_seen = 0; n_sel_seen = 0; n_err_seen = 0;
    push_frame(24'h400000, 24'h000200, 0);
    send_q(0, 1);
    chk("bad_err_count", 64'(n_err_seen), 64'd1);
    chk("bad_ch_count",  64'(n_ch_seen),  64'd0);
    chk("bad_sel_count", 64'(n_sel_seen), 64'd0);

    // Abort after channel 3's second byte, restart merged with a byte.
    n_err_seen = 0;
    push_word(24'hC0FFEE);
    for (int k = 0; k < 3; k++) push_word(24'($urandom));
    tx_q.push_back(8'h12); tx_q.push_back(8'h34);
    send_q(2, 1);
    n_ch_seen = 0;
    push_frame(24'hC00000, 24'h000100, 0);
    send_q(0, 2);
    step(0, 0, 0, 8'd0);
    chk("abort_err_count", 64'(n_err_seen), 64'd1);
    chk("abort_ch_count",  64'(n_ch_seen),  64'd8);
    chk("abort_sel_value", 64'(sel_data),   64'd258);

    // Gapped directed frame, then random frames.
    push_frame(24'hC00000, 24'h000100, 0);
    send_q(5, 1);
    chk("gap_sel_value", 64'(sel_data), 64'd258);
    for (int f = 0; f < 14; f++) begin
      push_frame({($urandom_range(3, 0) == 0) ? 4'h4 : 4'hC, 20'($urandom)}, 24'd0, 1);
      send_q($urandom_range(5, 0), $urandom_range(2, 1));
      for (int g = $urandom_range(3, 0); g > 0; g--) step(0, 0, $urandom_range(1, 0) == 1, 8'($urandom));
    end

    // Reset mid-frame in the channel section.
    push_word(24'hC00000); push_word(24'h111111); push_word(24'h222222); tx_q.push_back(8'h33);
    send_q(1, 1);
    step(1, 0, 1, 8'h44);
    chk("rst_ch_data",  64'(ch_data),  64'd0);
    chk("rst_sel_data", 64'(sel_data), 64'd0);
    chk("rst_status",   64'(status),   64'd0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 8'($urandom));
    n_ch_seen = 0;
    push_frame(24'hC00000, 24'h000100, 0);
    send_q(2, 1);
    step(0, 0, 0, 8'd0);
    chk("post_rst_ch_count", 64'(n_ch_seen), 64'd8);
    chk("post_rst_sel",      64'(sel_data),  64'd258);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
